display_timings_dvi: RTL and testbench

- Pixel-clock-domain raster timing generator.
- Produces the screen position, display enable and sync signals that feed the three TMDS channel encoders: i_de for all channels, i_ctrl = {vsync, hsync} on channel 0.
- Also emits line and frame strobes so the pixel source can align its data.
- Default geometry: 640x480 @ 60 Hz (800x525 total, 25.2 MHz pixel clock).

---
 rtl/display_pkg.sv | 39 +++
 rtl/display_axis_counter.sv | 51 +++++
 rtl/display_timings_dvi.sv | 89 ++++++++
 tb/tb_display_timings_dvi.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared display constants: raster timing presets and the TMDS control symbols
// that the channel encoders emit during blanking.
package display_pkg;

  // 640x480 @ 60 Hz, 25.2 MHz pixel clock, negative syncs
  localparam int VGA_H_RES  = 640;
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;
  localparam int VGA_V_RES  = 480;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;
  localparam bit VGA_H_POL  = 1'b0;
  localparam bit VGA_V_POL  = 1'b0;

  // 1280x720 @ 60 Hz, 74.25 MHz pixel clock, positive syncs
  localparam int HD_H_RES   = 1280;
  localparam int HD_H_FP    = 110;
  localparam int HD_H_SYNC  = 40;
  localparam int HD_H_BP    = 220;
  localparam int HD_V_RES   = 720;
  localparam int HD_V_FP    = 5;
  localparam int HD_V_SYNC  = 5;
  localparam int HD_V_BP    = 20;
  localparam bit HD_H_POL   = 1'b1;
  localparam bit HD_V_POL   = 1'b1;

  // TMDS control symbols indexed by {c1, c0}
  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  function automatic int axis_total(input int res, input int fp, input int sync, input int bp);
    return res + fp + sync + bp;
  endfunction

endpackage

// File: rtl/display_axis_counter.sv
// One raster axis: a wrapping position counter with a registered sync output.
// o_active decodes the position this counter will hold after the current edge.
module display_axis_counter
  import display_pkg::*;
#(
  parameter int CORDW    = 10,
  parameter int TOTAL    = 800,
  parameter int RES      = 640,
  parameter int SYNC_BEG = 656,
  parameter int SYNC_END = 751,
  parameter bit POL      = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_adv,
  output logic             o_wrap,
  output logic [CORDW-1:0] o_pos,
  output logic             o_active,
  output logic             o_sync
);

  localparam logic [CORDW-1:0] LAST  = CORDW'(TOTAL - 1);
  localparam logic [CORDW-1:0] RES_C = CORDW'(RES);
  localparam logic [CORDW-1:0] SB_C  = CORDW'(SYNC_BEG);
  localparam logic [CORDW-1:0] SE_C  = CORDW'(SYNC_END);

  logic [CORDW-1:0] pos_nxt;
  logic             sync_nxt;

  always_comb begin
    pos_nxt = o_pos;
    if (i_adv) begin
      pos_nxt = o_wrap ? '0 : o_pos + CORDW'(1);
    end
    sync_nxt = ((pos_nxt >= SB_C) && (pos_nxt <= SE_C)) ? POL : ~POL;
  end

  assign o_wrap   = (o_pos == LAST);
  assign o_active = (pos_nxt < RES_C);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pos  <= LAST;
      o_sync <= ~POL;
    end else if (i_adv) begin
      o_pos  <= pos_nxt;
      o_sync <= sync_nxt;
    end
  end

endmodule

// File: rtl/display_timings_dvi.sv
// Pixel-clock raster timing generator feeding the TMDS encoders: position,
// display enable, syncs and line/frame strobes, all registered and aligned.
module display_timings_dvi
  import display_pkg::*;
#(
  parameter int CORDW  = 10,
  parameter int H_RES  = VGA_H_RES,
  parameter int H_FP   = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP   = VGA_H_BP,
  parameter int V_RES  = VGA_V_RES,
  parameter int V_FP   = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP   = VGA_V_BP,
  parameter bit H_POL  = VGA_H_POL,
  parameter bit V_POL  = VGA_V_POL
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ce,
  output logic [CORDW-1:0] o_sx,
  output logic [CORDW-1:0] o_sy,
  output logic             o_de,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_line,
  output logic             o_frame
);

  localparam int H_TOTAL = axis_total(H_RES, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_RES, V_FP, V_SYNC, V_BP);
  localparam int HS_BEG  = H_RES + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC - 1;
  localparam int VS_BEG  = V_RES + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC - 1;

  if ((H_TOTAL - 1 >= (2 ** CORDW)) || (V_TOTAL - 1 >= (2 ** CORDW))) begin : g_cordw_check
    $error("CORDW too narrow to hold the raster totals");
  end

  logic h_wrap, h_active;
  logic v_wrap, v_active;
  logic v_adv;

  // The vertical axis steps only on the enabled edge that wraps the line.
  assign v_adv = i_ce & h_wrap;

  display_axis_counter #(
    .CORDW(CORDW), .TOTAL(H_TOTAL), .RES(H_RES),
    .SYNC_BEG(HS_BEG), .SYNC_END(HS_END), .POL(H_POL)
  ) u_h_axis (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_adv    (i_ce),
    .o_wrap   (h_wrap),
    .o_pos    (o_sx),
    .o_active (h_active),
    .o_sync   (o_hsync)
  );

  display_axis_counter #(
    .CORDW(CORDW), .TOTAL(V_TOTAL), .RES(V_RES),
    .SYNC_BEG(VS_BEG), .SYNC_END(VS_END), .POL(V_POL)
  ) u_v_axis (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_adv    (v_adv),
    .o_wrap   (v_wrap),
    .o_pos    (o_sy),
    .o_active (v_active),
    .o_sync   (o_vsync)
  );

  // Strobes fire only on an advancing edge, so a stall never repeats them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_de    <= 1'b0;
      o_line  <= 1'b0;
      o_frame <= 1'b0;
    end else begin
      o_line  <= i_ce & h_wrap;
      o_frame <= i_ce & h_wrap & v_wrap;
      if (i_ce) begin
        o_de <= h_active & v_active;
      end
    end
  end

endmodule

// File: tb/tb_display_timings_dvi.sv
// Bench for display_timings_dvi: three geometries share one stimulus stream,
// each checked cycle by cycle against a behavioural raster model.
module tb_display_timings_dvi;

  localparam int HR[3] = '{640, 40, 4};
  localparam int HF[3] = '{16, 4, 1};
  localparam int HW[3] = '{96, 8, 2};
  localparam int HB[3] = '{48, 4, 1};
  localparam int VR[3] = '{480, 30, 3};
  localparam int VF[3] = '{10, 2, 1};
  localparam int VW[3] = '{2, 2, 1};
  localparam int VB[3] = '{33, 3, 1};
  localparam bit HP[3] = '{1'b0, 1'b0, 1'b1};
  localparam bit VP[3] = '{1'b0, 1'b0, 1'b0};

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_ce  = 1'b0;

  logic [9:0] sx0, sy0, sx1, sy1;
  logic [2:0] sx2, sy2;
  logic de0, hs0, vs0, ln0, fr0;
  logic de1, hs1, vs1, ln1, fr1;
  logic de2, hs2, vs2, ln2, fr2;

  always #5 i_clk = ~i_clk;

  display_timings_dvi u_dut_vga (
    .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce),
    .o_sx(sx0), .o_sy(sy0), .o_de(de0), .o_hsync(hs0), .o_vsync(vs0),
    .o_line(ln0), .o_frame(fr0)
  );

  display_timings_dvi #(
    .CORDW(10), .H_RES(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_RES(30), .V_FP(2), .V_SYNC(2), .V_BP(3), .H_POL(1'b0), .V_POL(1'b0)
  ) u_dut_mid (
    .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce),
    .o_sx(sx1), .o_sy(sy1), .o_de(de1), .o_hsync(hs1), .o_vsync(vs1),
    .o_line(ln1), .o_frame(fr1)
  );

  display_timings_dvi #(
    .CORDW(3), .H_RES(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_RES(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b0)
  ) u_dut_small (
    .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce),
    .o_sx(sx2), .o_sy(sy2), .o_de(de2), .o_hsync(hs2), .o_vsync(vs2),
    .o_line(ln2), .o_frame(fr2)
  );

  // Scoreboard and counters
  logic [26:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state, one entry per instance
  int m_sx[3], m_sy[3];
  bit m_de[3], m_hs[3], m_vs[3], m_ln[3], m_fr[3];

  // Statistics gathered while the matching flag is set
  bit st_line = 0, st_frm = 0, st_small = 0;
  int hs_cnt = 0, hs_first = -1, hs_last = -1, de_cnt = 0;
  int nfr = 0, last_fr = 0, de_acc = 0, vs_acc = 0;
  int per_last = 0, de_last = 0, vs_last = 0;
  int sm_frames = 0, sm_lines = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] pack(input int k, input int sx, input int sy,
                                       input bit de, input bit hs, input bit vs,
                                       input bit ln, input bit fr);
    return {2'(k), 10'(sx), 10'(sy), de, hs, vs, ln, fr};
  endfunction

  function automatic logic [26:0] observed(input int k);
    case (k)
      0:       return {2'd0, sx0, sy0, de0, hs0, vs0, ln0, fr0};
      1:       return {2'd1, sx1, sy1, de1, hs1, vs1, ln1, fr1};
      default: return {2'd2, 7'd0, sx2, 7'd0, sy2, de2, hs2, vs2, ln2, fr2};
    endcase
  endfunction

  task automatic model_step(input int k, input bit ce, input bit rst);
    int ht, vt, hsb, vsb;
    ht  = HR[k] + HF[k] + HW[k] + HB[k];
    vt  = VR[k] + VF[k] + VW[k] + VB[k];
    hsb = HR[k] + HF[k];
    vsb = VR[k] + VF[k];
    if (rst) begin
      m_sx[k] = ht - 1; m_sy[k] = vt - 1;
      m_de[k] = 0; m_hs[k] = !HP[k]; m_vs[k] = !VP[k];
      m_ln[k] = 0; m_fr[k] = 0;
    end else if (ce) begin
      if (m_sx[k] == ht - 1) begin
        m_sx[k] = 0;
        m_sy[k] = (m_sy[k] == vt - 1) ? 0 : m_sy[k] + 1;
      end else begin
        m_sx[k] = m_sx[k] + 1;
      end
      m_de[k] = (m_sx[k] < HR[k]) && (m_sy[k] < VR[k]);
      m_hs[k] = (m_sx[k] >= hsb && m_sx[k] < hsb + HW[k]) ? HP[k] : !HP[k];
      m_vs[k] = (m_sy[k] >= vsb && m_sy[k] < vsb + VW[k]) ? VP[k] : !VP[k];
      m_ln[k] = (m_sx[k] == 0);
      m_fr[k] = (m_sx[k] == 0) && (m_sy[k] == 0);
    end else begin
      m_ln[k] = 0; m_fr[k] = 0;
    end
  endtask

  task automatic cycle(input logic ce, input logic rst);
    logic [26:0] exp_v;
    i_ce  = ce;
    i_rst = rst;
    for (int k = 0; k < 3; k++) begin
      model_step(k, ce, rst);
      exp_q.push_back(pack(k, m_sx[k], m_sy[k], m_de[k], m_hs[k], m_vs[k], m_ln[k], m_fr[k]));
    end
    @(posedge i_clk);
    #1;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      exp_v = exp_q.pop_front();
      chk($sformatf("raster%0d", k), 32'(observed(k)), 32'(exp_v));
    end
    if (st_line) begin
      if (!hs0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(sx0);
        hs_last = int'(sx0);
      end
      if (de0) de_cnt++;
    end
    if (st_frm) begin
      if (fr1) begin
        if (nfr > 0) begin
          per_last = cyc - last_fr; de_last = de_acc; vs_last = vs_acc;
        end
        nfr++; last_fr = cyc; de_acc = 0; vs_acc = 0;
      end
      if (de1) de_acc++;
      if (!vs1) vs_acc++;
    end
    if (st_small) begin
      if (fr2) sm_frames++;
      if (ln2) sm_lines++;
    end
  endtask

  task automatic run_until_sx0(input int target, input int budget);
    for (int i = 0; i < budget && int'(sx0) != target; i++) cycle(1'b1, 1'b0);
    chk("wait_sx", 32'(sx0), 32'(target));
  endtask

  initial begin
    // Reset, with reset values checked on the VGA instance
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
    chk("rst_sx", 32'(sx0), 32'd799);
    chk("rst_sy", 32'(sy0), 32'd524);
    chk("rst_de", 32'(de0), 32'd0);
    chk("rst_hs", 32'(hs0), 32'd1);
    chk("rst_vs", 32'(vs0), 32'd1);
    chk("rst_small_hs", 32'(hs2), 32'd0);

    // First enabled edge after release, then the rest of line 0
    st_line = 1;
    cycle(1'b1, 1'b0);
    chk("first_sx", 32'(sx0), 32'd0);
    chk("first_sy", 32'(sy0), 32'd0);
    chk("first_de", 32'(de0), 32'd1);
    chk("first_frame", 32'(fr0), 32'd1);
    chk("first_line", 32'(ln0), 32'd1);
    chk("first_hs", 32'(hs0), 32'd1);
    chk("first_vs", 32'(vs0), 32'd1);
    for (int i = 0; i < 799; i++) cycle(1'b1, 1'b0);
    st_line = 0;
    chk("hs_width", 32'(hs_cnt), 32'd96);
    chk("hs_first", 32'(hs_first), 32'd656);
    chk("hs_last", 32'(hs_last), 32'd751);
    chk("de_line", 32'(de_cnt), 32'd640);
    cycle(1'b1, 1'b0);
    chk("wrap_sx", 32'(sx0), 32'd0);
    chk("wrap_sy", 32'(sy0), 32'd1);
    chk("wrap_line", 32'(ln0), 32'd1);

    // Frame-level statistics on the mid-size raster (56 x 37)
    st_frm = 1;
    for (int i = 0; i < 3 * 2072 + 10 && nfr < 3; i++) cycle(1'b1, 1'b0);
    st_frm = 0;
    chk("frames_seen", 32'(nfr), 32'd3);
    chk("frame_period", 32'(per_last), 32'd2072);
    chk("frame_de", 32'(de_last), 32'd1200);
    chk("frame_vsync", 32'(vs_last), 32'd112);

    // Stall mid-line, then stall right before a line wrap
    run_until_sx0(10, 900);
    cycle(1'b0, 1'b0);
    chk("stall_sx_a", 32'(sx0), 32'd10);
    chk("stall_line_a", 32'(ln0), 32'd0);
    cycle(1'b0, 1'b0);
    chk("stall_sx_b", 32'(sx0), 32'd10);
    cycle(1'b1, 1'b0);
    chk("resume_sx", 32'(sx0), 32'd11);
    run_until_sx0(799, 900);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    chk("line_once", 32'(ln0), 32'd1);
    cycle(1'b0, 1'b0);
    chk("line_stall_sx", 32'(sx0), 32'd0);
    chk("line_no_dup", 32'(ln0), 32'd0);
    cycle(1'b1, 1'b0);
    chk("line_after", 32'(ln0), 32'd0);

    // Random clock-enable pattern
    for (int i = 0; i < 300; i++) cycle(logic'($urandom_range(0, 3) != 0), 1'b0);

    // Reset mid-line, with clock enable still high
    run_until_sx0(300, 900);
    cycle(1'b1, 1'b1);
    chk("mrst_sx", 32'(sx0), 32'd799);
    chk("mrst_sy", 32'(sy0), 32'd524);
    chk("mrst_de", 32'(de0), 32'd0);
    cycle(1'b1, 1'b0);
    chk("mrst_frame", 32'(fr0), 32'd1);
    chk("mrst_origin", 32'({sx0, sy0}), 32'd0);

    // Three full frames of the small raster (8 x 6)
    st_small = 1;
    for (int i = 0; i < 144; i++) cycle(1'b1, 1'b0);
    st_small = 0;
    chk("small_frames", 32'(sm_frames), 32'd3);
    chk("small_lines", 32'(sm_lines), 32'd18);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
